// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states,
// ALU operation classes and datapath mux selects.
package cpu_ctrl_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned STATE_W  = 4;

  localparam logic [OPCODE_W-1:0] OP_R    = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J    = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 6'b001000;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_LW   = 3'd1,
    CLS_SW   = 3'd2,
    CLS_BEQ  = 3'd3,
    CLS_J    = 3'd4,
    CLS_ADDI = 3'd5,
    CLS_ILL  = 3'd6
  } instr_class_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/opcode_classify.sv
// Combinational opcode decoder: maps the IR opcode field to an instruction class.
module opcode_classify
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [2:0] cls_c,
  output logic       illegal_c
);

  // Class lookup; anything unrecognised is flagged illegal
  always_comb begin
    cls_c     = 3'(CLS_ILL);
    illegal_c = 1'b0;
    unique case (opcode)
      OP_R:    cls_c = 3'(CLS_R);
      OP_LW:   cls_c = 3'(CLS_LW);
      OP_SW:   cls_c = 3'(CLS_SW);
      OP_BEQ:  cls_c = 3'(CLS_BEQ);
      OP_J:    cls_c = 3'(CLS_J);
      OP_ADDI: cls_c = 3'(CLS_ADDI);
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: steps shared memory, ALU and register file through
// fetch/decode/execute/memory/write-back, stretching memory phases on mem_ready.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             trap,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire_c;
  logic [2:0]       cls_c;
  logic             illegal_c;

  // zero is consumed by the datapath's PC-enable gate, not by the sequencer
  logic unused_c;
  assign unused_c = zero;

  opcode_classify u_classify (
    .opcode    (opcode),
    .cls_c     (cls_c),
    .illegal_c (illegal_c)
  );

  // State register and retirement counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire_c) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign state   = 4'(state_q);
  assign retired = retired_q;

  // Next-state and Moore output decode; strobes squashed while in reset
  always_comb begin
    state_d       = state_q;
    retire_c      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    trap          = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        if (illegal_c) begin
          state_d = S_TRAP;
        end else begin
          case (instr_class_e'(cls_c))
            CLS_LW, CLS_SW: state_d = S_MEM_ADDR;
            CLS_R:          state_d = S_R_EXEC;
            CLS_BEQ:        state_d = S_BRANCH;
            CLS_J:          state_d = S_JUMP;
            CLS_ADDI:       state_d = S_ADDI_EXEC;
            default:        state_d = S_TRAP;
          endcase
        end
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (instr_class_e'(cls_c) == CLS_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
        retire_c   = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          state_d  = S_FETCH;
          retire_c = 1'b1;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_op    = ALU_FUNCT;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
        retire_c  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        state_d       = S_FETCH;
        retire_c      = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        state_d   = S_FETCH;
        retire_c  = 1'b1;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
        retire_c  = 1'b1;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    if (!rst_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state/strobe vectors with
// hand-computed expectations plus spot checks of mux selects and counters.
module tb_multicycle_control;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, trap;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [31:0] retired;

  int unsigned n_vec;
  int unsigned n_err;

  // Strobe bundle: {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write}
  logic [5:0] strb;
  assign strb = {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write};

  multicycle_control #(.CNT_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .trap          (trap),
    .state         (state),
    .retired       (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle's inputs (just after negedge) and check state and strobes
  task automatic apply(input logic rn, input logic [5:0] op, input logic mr,
                       input logic [3:0] es, input logic [5:0] estb);
    rst_n     = rn;
    opcode    = op;
    mem_ready = mr;
    #1;
    chk("state", 32'(state), 32'(es));
    chk("strobes", 32'(strb), 32'(estb));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] BAD  = 6'b111111;

  localparam logic [5:0] ST_FETCH = 6'b101010;
  localparam logic [5:0] ST_FWAIT = 6'b001000;
  localparam logic [5:0] ST_MRD   = 6'b001000;
  localparam logic [5:0] ST_MWR   = 6'b000100;
  localparam logic [5:0] ST_RW    = 6'b000001;
  localparam logic [5:0] ST_BR    = 6'b010000;
  localparam logic [5:0] ST_JMP   = 6'b100000;
  localparam logic [5:0] ST_NONE  = 6'b000000;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    opcode = RT;
    zero = 1'b0;
    mem_ready = 1'b0;
    tick();

    // Reset: FETCH with mem_ready high but strobes squashed
    apply(1'b0, LW, 1'b1, 4'd0, ST_NONE);
    chk("rst_retired", retired, 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    tick();

    // LW, memory always ready: 0,1,2,3,4 then back to FETCH
    apply(1'b1, LW, 1'b1, 4'd0, ST_FETCH);
    chk("fetch_srcb", 32'(alu_src_b), 32'd1);
    chk("fetch_iord", 32'(i_or_d), 32'd0);
    tick();
    apply(1'b1, LW, 1'b1, 4'd1, ST_NONE);
    chk("dec_srcb", 32'(alu_src_b), 32'd3);
    tick();
    apply(1'b1, LW, 1'b1, 4'd2, ST_NONE);
    chk("addr_srcb", 32'(alu_src_b), 32'd2);
    chk("addr_srca", 32'(alu_src_a), 32'd1);
    tick();
    apply(1'b1, LW, 1'b1, 4'd3, ST_MRD);
    chk("mrd_iord", 32'(i_or_d), 32'd1);
    chk("mrd_m2r", 32'(mem_to_reg), 32'd0);
    tick();
    apply(1'b1, LW, 1'b1, 4'd4, ST_RW);
    chk("mwb_m2r", 32'(mem_to_reg), 32'd1);
    chk("mwb_regdst", 32'(reg_dst), 32'd0);
    tick();
    apply(1'b1, SW, 1'b1, 4'd0, ST_FETCH);
    chk("lw_retired", retired, 32'd1);
    tick();

    // SW with three wait cycles in MEM_WRITE: 7 cycles total
    apply(1'b1, SW, 1'b1, 4'd1, ST_NONE);
    tick();
    apply(1'b1, SW, 1'b0, 4'd2, ST_NONE);
    tick();
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, SW, (i == 3) ? 1'b1 : 1'b0, 4'd5, ST_MWR);
      chk("mwr_iord", 32'(i_or_d), 32'd1);
      tick();
    end

    // FETCH stalled two cycles, then an R-type
    apply(1'b1, RT, 1'b0, 4'd0, ST_FWAIT);
    chk("sw_retired", retired, 32'd2);
    tick();
    apply(1'b1, RT, 1'b0, 4'd0, ST_FWAIT);
    tick();
    apply(1'b1, RT, 1'b1, 4'd0, ST_FETCH);
    tick();
    apply(1'b1, RT, 1'b1, 4'd1, ST_NONE);
    tick();
    apply(1'b1, RT, 1'b1, 4'd6, ST_NONE);
    chk("rexec_aluop", 32'(alu_op), 32'd2);
    chk("rexec_srcb", 32'(alu_src_b), 32'd0);
    tick();
    apply(1'b1, RT, 1'b1, 4'd7, ST_RW);
    chk("rwb_regdst", 32'(reg_dst), 32'd1);
    tick();
    // Reset between groups so the back-to-back run starts from a zero count
    apply(1'b0, BEQ, 1'b1, 4'd0, ST_NONE);
    chk("r_retired", retired, 32'd3);
    tick();

    // BEQ, J, R, ADDI back-to-back (3,3,4,4 cycles); mem_ready ignored in DECODE
    apply(1'b1, BEQ, 1'b1, 4'd0, ST_FETCH);
    chk("beq_start_ret", retired, 32'd0);
    tick();
    apply(1'b1, BEQ, 1'b0, 4'd1, ST_NONE);
    tick();
    apply(1'b1, BEQ, 1'b0, 4'd8, ST_BR);
    chk("br_pcsrc", 32'(pc_source), 32'd1);
    chk("br_aluop", 32'(alu_op), 32'd1);
    tick();
    apply(1'b1, JMP, 1'b1, 4'd0, ST_FETCH);
    tick();
    apply(1'b1, JMP, 1'b1, 4'd1, ST_NONE);
    tick();
    apply(1'b1, JMP, 1'b1, 4'd9, ST_JMP);
    chk("jmp_pcsrc", 32'(pc_source), 32'd2);
    tick();
    apply(1'b1, RT, 1'b1, 4'd0, ST_FETCH);
    tick();
    apply(1'b1, RT, 1'b1, 4'd1, ST_NONE);
    tick();
    apply(1'b1, RT, 1'b1, 4'd6, ST_NONE);
    tick();
    apply(1'b1, RT, 1'b1, 4'd7, ST_RW);
    tick();
    apply(1'b1, ADDI, 1'b1, 4'd0, ST_FETCH);
    tick();
    apply(1'b1, ADDI, 1'b1, 4'd1, ST_NONE);
    tick();
    apply(1'b1, ADDI, 1'b1, 4'd10, ST_NONE);
    chk("addi_srcb", 32'(alu_src_b), 32'd2);
    tick();
    apply(1'b1, ADDI, 1'b1, 4'd11, ST_RW);
    chk("addi_regdst", 32'(reg_dst), 32'd0);
    chk("addi_m2r", 32'(mem_to_reg), 32'd0);
    tick();

    // Illegal opcode: DECODE -> TRAP, sticky with all strobes low
    apply(1'b1, BAD, 1'b1, 4'd0, ST_FETCH);
    chk("b2b_retired", retired, 32'd4);
    tick();
    apply(1'b1, BAD, 1'b1, 4'd1, ST_NONE);
    tick();
    for (int i = 0; i < 11; i++) begin
      apply(1'b1, (i % 2 == 0) ? BAD : LW, 1'(i % 2), 4'd12, ST_NONE);
      chk("trap_flag", 32'(trap), 32'd1);
      tick();
    end
    chk("trap_retired", retired, 32'd4);
    apply(1'b0, BAD, 1'b1, 4'd12, ST_NONE);
    tick();
    apply(1'b1, LW, 1'b0, 4'd0, ST_FWAIT);
    chk("trap_clr", 32'(trap), 32'd0);
    chk("trap_rst_ret", retired, 32'd0);
    tick();

    // Reset asserted during MEM_READ abandons the load
    apply(1'b1, LW, 1'b1, 4'd0, ST_FETCH);
    tick();
    apply(1'b1, LW, 1'b1, 4'd1, ST_NONE);
    tick();
    apply(1'b1, LW, 1'b1, 4'd2, ST_NONE);
    tick();
    apply(1'b0, LW, 1'b1, 4'd3, ST_NONE);
    tick();
    apply(1'b1, LW, 1'b0, 4'd0, ST_FWAIT);
    chk("abort_retired", retired, 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multi-cycle version of the MIPS CPU. It replaces the single-cycle `controlUnit` with a state machine that steps one shared memory, one ALU and the register file through fetch, decode, execute, memory and write-back phases, one phase per clock. It stretches memory phases until the memory acknowledges, traps on unsupported opcodes and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock, all state changes on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `opcode`  in  6  instruction[31:26] taken from the instruction register
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current read or write this cycle
- `pc_write`  out  1  unconditional PC load
- `pc_write_cond`  out  1  PC load when `zero`=1 (BEQ)
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_read`  out  1  memory read strobe
- `mem_write`  out  1  memory write strobe
- `ir_write`  out  1  instruction register load
- `reg_dst`  out  1  write register select: 0 = rt, 1 = rd
- `mem_to_reg`  out  1  write data select: 0 = ALUOut, 1 = MDR
- `reg_write`  out  1  register file write enable
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = register A
- `alu_src_b`  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- `alu_op`  out  2  operation class: 00 = add, 01 = subtract, 10 = decode funct
- `pc_source`  out  2  next PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `trap`  out  1  sticky illegal-opcode flag
- `state`  out  4  current state encoding, for debug
- `retired`  out  CNT_W  count of completed instructions

## Operation
Supported opcodes:
- R-type 000000
- LW 100011
- SW 101011
- BEQ 000100
- J 000010
- ADDI 001000

Any other opcode is illegal.

States and encodings:
- FETCH(0): `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00. `ir_write` and `pc_write` assert only in the cycle `mem_ready`=1. Stays in FETCH while `mem_ready`=0; otherwise goes to DECODE.
- DECODE(1): `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (computes the branch target). Next state by opcode:
  - LW or SW → MEM_ADDR
  - R-type → R_EXEC
  - BEQ → BRANCH
  - J → JUMP
  - ADDI → ADDI_EXEC
  - any other opcode → TRAP
- MEM_ADDR(2): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state is MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ(3): `mem_read`=1, `i_or_d`=1. Holds until `mem_ready`, then goes to MEM_WB.
- MEM_WB(4): `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Next state FETCH.
- MEM_WRITE(5): `mem_write`=1, `i_or_d`=1. Holds until `mem_ready`, then goes to FETCH.
- R_EXEC(6): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next state R_WB.
- R_WB(7): `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Next state FETCH.
- BRANCH(8): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01. Next state FETCH.
- JUMP(9): `pc_write`=1, `pc_source`=10. Next state FETCH.
- ADDI_EXEC(10): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state ADDI_WB.
- ADDI_WB(11): `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Next state FETCH.
- TRAP(12): all strobes 0, `trap`=1. Exited only by reset.

General rules:
- Any output not listed for a state is 0.
- `retired` increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP or ADDI_WB. It wraps modulo 2^CNT_W.
- `mem_ready` is ignored outside FETCH, MEM_READ and MEM_WRITE.
- Unused encodings 13–15 go to FETCH on the next edge and are not counted as retirements.

## Timing
- Reset:
  - A rising edge of `clk` with `rst_n`=0 sets state to FETCH, `retired` to 0 and `trap` to 0.
  - While `rst_n`=0, every strobe output is forced to 0 combinationally: `pc_write`, `pc_write_cond`, `mem_read`, `mem_write`, `ir_write`, `reg_write`.
  - Reset mid-instruction abandons the instruction; no strobe fires in that cycle.
- Output decode:
  - Outputs are Moore-decoded from the state register.
  - The only exceptions are `ir_write` and `pc_write` in FETCH, which are additionally qualified by `mem_ready`.
- Latency with `mem_ready` held at 1:
  - R-type: 4 cycles
  - ADDI: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BEQ: 3 cycles
  - J: 3 cycles
- Each cycle of `mem_ready`=0 in a memory state adds exactly one cycle to the instruction.
- `opcode` is sampled only in DECODE and MEM_ADDR. The IR is stable there because `ir_write` is 0 outside FETCH.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - opcode constants (R, LW, SW, BEQ, J, ADDI)
  - the 4-bit state enum with the fixed encodings above
  - `alu_op`, `alu_src_b` and `pc_source` encodings, shared with ALUControl and the datapath muxes
- Sub-module `opcode_classify`: combinational opcode → instruction class plus an illegal flag. Used in DECODE and MEM_ADDR.
- The top level holds the state register, next-state logic, output decode and the `retired` counter.

## Test plan
- Reset, then a LW with `mem_ready`=1: states 0,1,2,3,4,0. `reg_write`=1 and `mem_to_reg`=1 only in cycle 5. `retired`=1.
- SW with `mem_ready` low for 3 cycles in MEM_WRITE: `mem_write` held for 4 cycles, `i_or_d`=1 throughout, 7 cycles total, `retired` increments once.
- FETCH with `mem_ready`=0 for 2 cycles: `ir_write` and `pc_write` stay 0 until the third cycle, then pulse for exactly 1 cycle.
- BEQ, then J, then R-type, then ADDI back-to-back: cycle counts 3, 3, 4, 4. `pc_write_cond`=1 only in BRANCH; `pc_source`=10 in JUMP. `retired`=4.
- Opcode 111111: DECODE→TRAP, `trap`=1 and all strobes 0 for 10+ cycles. Then `rst_n`=0 for one edge: state=0, `trap`=0, `retired`=0.
- `rst_n` driven low during MEM_READ: strobes 0 in that cycle, state FETCH on the next edge, no register write.
